// File: rtl/mcast_lock_arbiter.sv
// All-or-nothing multicast arbiter: an ingress is connected only when it wins every egress
// in its mask, holds them until eop, and a starvation token protects wide requests.
module mcast_lock_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int SEL_W        = $clog2(NUM_PORTS),
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] dst,
  input  logic [NUM_PORTS-1:0]         eop,
  output logic [NUM_PORTS-1:0]         grant,
  output logic [NUM_PORTS-1:0]         conn,
  output logic [NUM_PORTS*SEL_W-1:0]   out_sel,
  output logic [NUM_PORTS-1:0]         out_active,
  output logic [NUM_PORTS-1:0]         starved
);
  localparam int N = NUM_PORTS;

  logic [N-1:0]            lock_q, lock_d, conn_q, conn_d, grant_q, grant_d;
  logic [N-1:0][SEL_W-1:0] owner_q, owner_d, ptr_q, ptr_d;
  logic [N-1:0][7:0]       cnt_q, cnt_d;
  logic                    tok_vld_q, tok_vld_d;
  logic [SEL_W-1:0]        tok_idx_q, tok_idx_d;

  logic [N-1:0][N-1:0]     dst_m;   // dst_m[ingress][egress]
  logic [N-1:0][N-1:0]     win;     // win[egress][ingress], one-hot or zero
  logic [N-1:0]            elig, starved_w;

  always_comb begin
    for (int i = 0; i < N; i++)
      for (int o = 0; o < N; o++)
        dst_m[i][o] = dst[i*N + o];
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i]      = req[i] & ~conn_q[i] & (|dst_m[i]);
      starved_w[i] = (cnt_q[i] == 8'(STARVE_LIMIT));
    end
  end

  // Per-egress round-robin; a reserved egress only accepts the token owner.
  always_comb begin
    logic [N-1:0] cand;
    logic         found;
    int           idx;
    win = '0;
    for (int o = 0; o < N; o++) begin
      cand = '0;
      for (int i = 0; i < N; i++)
        cand[i] = elig[i] & dst_m[i][o] & ~lock_q[o];
      if (tok_vld_q && dst_m[tok_idx_q][o])
        cand = cand & (N'(1) << tok_idx_q);
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q[o]) + k;
        if (idx >= N) idx -= N;
        if (!found && cand[idx[SEL_W-1:0]]) begin
          win[o][idx[SEL_W-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic won;
    grant_d = '0;
    for (int i = 0; i < N; i++) begin
      won = 1'b1;
      for (int o = 0; o < N; o++)
        if (dst_m[i][o] && !win[o][i]) won = 1'b0;
      grant_d[i] = elig[i] & won;
    end
  end

  // Releases first; a grant can never land on an egress that was locked this cycle.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    conn_d  = conn_q;
    for (int i = 0; i < N; i++) begin
      if (eop[i] && conn_q[i]) begin
        conn_d[i] = 1'b0;
        for (int o = 0; o < N; o++)
          if (lock_q[o] && owner_q[o] == SEL_W'(i)) lock_d[o] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (grant_d[i]) begin
        conn_d[i] = 1'b1;
        for (int o = 0; o < N; o++) begin
          if (dst_m[i][o]) begin
            lock_d[o]  = 1'b1;
            owner_d[o] = SEL_W'(i);
            ptr_d[o]   = (i == N-1) ? '0 : SEL_W'(i + 1);
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (!req[i] || grant_d[i])
        cnt_d[i] = '0;
      else if (elig[i] && !starved_w[i])
        cnt_d[i] = cnt_q[i] + 8'd1;
      else
        cnt_d[i] = cnt_q[i];
    end
  end

  always_comb begin
    tok_vld_d = tok_vld_q;
    tok_idx_d = tok_idx_q;
    if (tok_vld_q) begin
      if (grant_d[tok_idx_q] || !req[tok_idx_q]) tok_vld_d = 1'b0;
    end else begin
      for (int i = N-1; i >= 0; i--) begin
        if (starved_w[i]) begin
          tok_vld_d = 1'b1;
          tok_idx_d = SEL_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q    <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      conn_q    <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      tok_vld_q <= 1'b0;
      tok_idx_q <= '0;
    end else begin
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      conn_q    <= conn_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      tok_vld_q <= tok_vld_d;
      tok_idx_q <= tok_idx_d;
    end
  end

  always_comb begin
    out_sel = '0;
    for (int o = 0; o < N; o++)
      if (lock_q[o]) out_sel[o*SEL_W +: SEL_W] = owner_q[o];
  end

  assign grant      = grant_q;
  assign conn       = conn_q;
  assign out_active = lock_q;
  assign starved    = starved_w;

endmodule

// File: tb/tb_mcast_lock_arbiter.sv
// Directed and random stimulus for mcast_lock_arbiter, checked every cycle against a
// behavioural model of the connection/lock/starvation rules.
module tb_mcast_lock_arbiter;
  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int LIM = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, eop;
  logic [N*N-1:0]  dst;
  logic [N-1:0]    grant, conn, out_active, starved;
  logic [N*SW-1:0] out_sel;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [N-1:0] m_lock, m_conn, m_grant;
  int           m_owner[N], m_ptr[N], m_cnt[N];
  logic         m_tv;
  int           m_ti;

  mcast_lock_arbiter #(.NUM_PORTS(N), .SEL_W(SW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .req(req), .dst(dst), .eop(eop),
    .grant(grant), .conn(conn), .out_sel(out_sel),
    .out_active(out_active), .starved(starved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = '0; m_conn = '0; m_grant = '0; m_tv = 1'b0; m_ti = 0;
    for (int k = 0; k < N; k++) begin m_owner[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; end
  endtask

  // One clock edge of the arbitration rules, applied to the inputs held across that edge.
  task automatic model_step();
    logic [N-1:0] el, g, st;
    int win[N];
    int c;
    for (int k = 0; k < N; k++) begin
      el[k] = req[k] && !m_conn[k] && (dst[k*N +: N] != '0);
      st[k] = (m_cnt[k] == LIM);
    end
    for (int o = 0; o < N; o++) begin
      win[o] = -1;
      if (!m_lock[o])
        for (int k = 0; k < N; k++) begin
          c = (m_ptr[o] + k) % N;
          if (win[o] < 0 && el[c] && dst[c*N+o] && !(m_tv && dst[m_ti*N+o] && c != m_ti))
            win[o] = c;
        end
    end
    for (int a = 0; a < N; a++) begin
      g[a] = el[a];
      for (int o = 0; o < N; o++)
        if (dst[a*N+o] && win[o] != a) g[a] = 1'b0;
    end
    for (int a = 0; a < N; a++)
      if (eop[a] && m_conn[a]) begin
        m_conn[a] = 1'b0;
        for (int o = 0; o < N; o++)
          if (m_lock[o] && m_owner[o] == a) m_lock[o] = 1'b0;
      end
    for (int a = 0; a < N; a++)
      if (g[a]) begin
        m_conn[a] = 1'b1;
        for (int o = 0; o < N; o++)
          if (dst[a*N+o]) begin m_lock[o] = 1'b1; m_owner[o] = a; m_ptr[o] = (a + 1) % N; end
      end
    for (int a = 0; a < N; a++) begin
      if (!req[a] || g[a]) m_cnt[a] = 0;
      else if (el[a] && m_cnt[a] < LIM) m_cnt[a]++;
    end
    if (m_tv) begin
      if (g[m_ti] || !req[m_ti]) m_tv = 1'b0;
    end else begin
      for (int k = N-1; k >= 0; k--)
        if (st[k]) begin m_tv = 1'b1; m_ti = k; end
    end
    m_grant = g;
  endtask

  task automatic check_all();
    logic [N*SW-1:0] sel;
    logic [N-1:0]    stv;
    sel = '0;
    for (int o = 0; o < N; o++)
      if (m_lock[o]) sel[o*SW +: SW] = SW'(m_owner[o]);
    for (int k = 0; k < N; k++) stv[k] = (m_cnt[k] == LIM);
    chk("grant",      32'(grant),      32'(m_grant));
    chk("conn",       32'(conn),       32'(m_conn));
    chk("out_active", 32'(out_active), 32'(m_lock));
    chk("out_sel",    32'(out_sel),    32'(sel));
    chk("starved",    32'(starved),    32'(stv));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  initial begin
    logic seen;
    rst = 1'b1; req = '0; dst = '0; eop = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // unicast conflict on egress 2
    req = 4'b0011; dst = 16'h0044;
    cycle();
    chk("uc_grant0", 32'(grant), 32'h1);
    chk("uc_sel2",   32'(out_sel[2*SW +: SW]), 32'h0);
    cycle();
    eop = 4'b0001; req = 4'b0010;
    cycle();
    eop = '0;
    cycle();
    chk("uc_grant1", 32'(grant), 32'h2);
    chk("uc_sel2b",  32'(out_sel[2*SW +: SW]), 32'h1);
    eop = 4'b0010; req = '0;
    cycle();
    eop = '0;
    cycle();

    // set ptr[1]=1, then all-or-nothing multicast
    req = 4'b0001; dst = 16'h0002;
    cycle();
    eop = 4'b0001; req = '0;
    cycle();
    eop = '0;
    cycle();
    req = 4'b0011; dst = 16'h0026;
    cycle();
    chk("mc_grant", 32'(grant), 32'h2);
    chk("mc_act",   32'(out_active), 32'h2);
    cycle();
    chk("mc_hold",  32'(out_active), 32'h2);
    eop = 4'b0010; req = 4'b0001;
    cycle();
    eop = '0;
    cycle();
    chk("mc_late",  32'(grant), 32'h1);
    chk("mc_act2",  32'(out_active), 32'h6);
    eop = 4'b0001; req = '0;
    cycle();
    eop = '0;
    cycle();

    // disjoint parallel grants
    req = 4'b1111; dst = 16'h8421;
    cycle();
    chk("par_grant", 32'(grant), 32'hF);
    chk("par_sel",   32'(out_sel), 32'hE4);
    eop = 4'b1111; req = '0;
    cycle();
    eop = '0;
    cycle();

    // ptr wrap: ingress 3 on egress 0 leaves ptr[0]=0
    req = 4'b1000; dst = 16'h1000;
    cycle();
    eop = 4'b1000; req = '0;
    cycle();
    eop = '0;
    cycle();
    req = 4'b1001; dst = 16'h1001;
    cycle();
    chk("wrap_grant", 32'(grant), 32'h1);
    eop = 4'b0001; req = 4'b1000;
    cycle();
    eop = '0;
    cycle();
    eop = 4'b1000; req = '0;
    cycle();

    // stray eop on unconnected ingresses
    eop = 4'b0110;
    cycle();
    chk("stray_conn", 32'(conn), 32'h0);
    eop = '0;
    cycle();

    // starvation of a broadcast request
    req = 4'b1110; dst = 16'h8420;
    cycle();
    req = 4'b1111; dst = 16'h842F;
    repeat (LIM) cycle();
    chk("starve_flag", 32'(starved), 32'h1);
    eop = 4'b0010;
    cycle();
    eop = '0;
    cycle();
    chk("reserved_blk", 32'(grant), 32'h0);
    eop = 4'b0100;
    cycle();
    eop = '0;
    cycle();
    eop = 4'b1000;
    cycle();
    eop = '0;
    seen = 1'b0;
    for (int w = 0; w < 8 && !seen; w++) begin
      cycle();
      seen = grant[0];
    end
    chk("starve_grant", 32'(seen), 32'h1);
    eop = 4'b0001; req = '0;
    cycle();
    eop = '0;
    cycle();

    // reset mid-packet
    req = 4'b0101; dst = 16'h0401;
    cycle();
    cycle();
    chk("pre_rst_conn", 32'(conn), 32'h5);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_sel", 32'(out_sel), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; req = 4'b0011; dst = 16'h0011;
    cycle();
    chk("post_rst_ptr", 32'(grant), 32'h1);
    eop = 4'b0001; req = '0;
    cycle();
    eop = '0;
    cycle();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) begin
        req = N'($urandom);
        dst = (N*N)'($urandom);
      end
      eop = N'($urandom & $urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
